// File: rtl/canny_pkg.sv
`default_nettype none
// ============================================================================
// Module   : canny_pkg
// Brief    : Shared types and constants for the Canny edge-detection stages.
// Revision : 1.0 - initial release
// ============================================================================
package canny_pkg;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_t;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_PROLOGUE = 2'd0;
    localparam state_t c_ST_COMPUTE  = 2'd1;
    localparam state_t c_ST_OUTPUT   = 2'd2;

    // Sobel kernel weights: outer taps and the centre tap of each column/row
    localparam logic signed [10:0] c_SOBEL_SIDE   = 11'sd1;
    localparam logic signed [10:0] c_SOBEL_CENTRE = 11'sd2;

    localparam logic [7:0] c_MAG_MAX = 8'd255;

    function automatic logic signed [10:0] sobel_diff(
        input logic [7:0] pos_a,
        input logic [7:0] pos_m,
        input logic [7:0] pos_b,
        input logic [7:0] neg_a,
        input logic [7:0] neg_m,
        input logic [7:0] neg_b
    );
        logic signed [10:0] pos_sum;
        logic signed [10:0] neg_sum;
        pos_sum = c_SOBEL_SIDE   * $signed({3'b000, pos_a})
                + c_SOBEL_CENTRE * $signed({3'b000, pos_m})
                + c_SOBEL_SIDE   * $signed({3'b000, pos_b});
        neg_sum = c_SOBEL_SIDE   * $signed({3'b000, neg_a})
                + c_SOBEL_CENTRE * $signed({3'b000, neg_m})
                + c_SOBEL_SIDE   * $signed({3'b000, neg_b});
        return pos_sum - neg_sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_dir_quant.sv
`default_nettype none
// ============================================================================
// Module   : sobel_dir_quant
// Brief    : Quantizes a Sobel gradient (Gx, Gy) into one of four directions.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_dir_quant
    import canny_pkg::*;
(
    input  logic [10:0] gx,
    input  logic [10:0] gy,
    output logic [1:0]  dir
);

    logic [10:0] w_ax;
    logic [10:0] w_ay;
    logic [12:0] w_ax2;
    logic [12:0] w_ax5;
    logic [12:0] w_ay2;
    logic [12:0] w_ay5;

    always_comb begin
        w_ax  = gx[10] ? 11'(-gx) : gx;
        w_ay  = gy[10] ? 11'(-gy) : gy;
        w_ax2 = {1'b0, w_ax, 1'b0};
        w_ay2 = {1'b0, w_ay, 1'b0};
        w_ax5 = {2'b00, w_ax} + {w_ax, 2'b00};
        w_ay5 = {2'b00, w_ay} + {w_ay, 2'b00};

        // Sector tests use tan(22.5)~2/5 and tan(67.5)~5/2; zero gradient lands in DIR_0
        if (w_ay5 <= w_ax2) begin
            dir = DIR_0;
        end else if (w_ay2 >= w_ax5) begin
            dir = DIR_90;
        end else if (gx[10] == gy[10]) begin
            dir = DIR_45;
        end else begin
            dir = DIR_135;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_gradient.sv
`default_nettype none
// ============================================================================
// Module   : sobel_gradient
// Brief    : FIFO-to-FIFO 3x3 Sobel gradient magnitude stage (raster order).
//            Define SOBEL_DIRECTION_EN to add the quantized direction output.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_gradient
    import canny_pkg::*;
#(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic       clock,
    input  logic       reset,
    output logic       in_rd_en,
    input  logic       in_empty,
    input  logic [7:0] in_dout,
    output logic       out_wr_en,
    input  logic       out_full,
`ifdef SOBEL_DIRECTION_EN
    output logic [1:0] out_dir,
`endif
    output logic [7:0] out_din
);

    localparam int c_PIXELS = WIDTH * HEIGHT;
    localparam int c_WIN    = 2 * WIDTH + 3;
    localparam int c_CNT_W  = $clog2(c_PIXELS + 1);
    localparam int c_COL_W  = $clog2(WIDTH);
    localparam int c_ROW_W  = $clog2(HEIGHT);

    localparam logic [c_CNT_W-1:0] c_CNT_FULL     = c_CNT_W'(c_PIXELS);
    localparam logic [c_CNT_W-1:0] c_CNT_PRO_LAST = c_CNT_W'(WIDTH + 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST     = c_COL_W'(WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST     = c_ROW_W'(HEIGHT - 1);

    state_t             r_state;
    logic [7:0]         r_win [c_WIN];
    logic [c_CNT_W-1:0] r_in_cnt;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [7:0]         r_mag;

    logic        w_padding;
    logic        w_advance;
    logic        w_last;
    logic        w_frame_end;
    logic        w_border;
    logic [10:0] w_gx;
    logic [10:0] w_gy;
    logic [10:0] w_ax;
    logic [10:0] w_ay;
    logic [10:0] w_sum;
    logic [7:0]  w_mag;

    // Once every pixel of the frame has been read, advances shift in zeros
    assign w_padding   = (r_in_cnt == c_CNT_FULL);
    assign w_last      = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
    assign w_frame_end = (r_state == c_ST_OUTPUT) && out_wr_en && w_last;
    assign w_border    = (r_row == '0) || (r_row == c_ROW_LAST) ||
                         (r_col == '0) || (r_col == c_COL_LAST);

    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            c_ST_PROLOGUE: begin
                in_rd_en  = !in_empty && !w_padding;
                w_advance = in_rd_en;
            end
            c_ST_OUTPUT: begin
                out_wr_en = !out_full && (!in_empty || w_padding);
                in_rd_en  = out_wr_en && !w_padding;
                w_advance = out_wr_en;
            end
            default: begin
                w_advance = 1'b0;
            end
        endcase
    end

    // Taps: row 0 is the line above the centre, row 2 the line below
    assign w_gx = sobel_diff(r_win[2], r_win[WIDTH+2], r_win[2*WIDTH+2],
                             r_win[0], r_win[WIDTH],   r_win[2*WIDTH]);
    assign w_gy = sobel_diff(r_win[2*WIDTH], r_win[2*WIDTH+1], r_win[2*WIDTH+2],
                             r_win[0],       r_win[1],         r_win[2]);

    always_comb begin
        w_ax  = w_gx[10] ? 11'(-w_gx) : w_gx;
        w_ay  = w_gy[10] ? 11'(-w_gy) : w_gy;
        w_sum = w_ax + w_ay;
        w_mag = (w_sum > {3'b000, c_MAG_MAX}) ? c_MAG_MAX : w_sum[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_WIN; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_frame_end) begin
            for (int i = 0; i < c_WIN; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_advance) begin
            for (int i = 0; i < c_WIN - 1; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[c_WIN-1] <= in_rd_en ? in_dout : 8'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= c_ST_PROLOGUE;
            r_in_cnt <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_mag    <= '0;
        end else begin
            case (r_state)
                c_ST_PROLOGUE: begin
                    if (in_rd_en) begin
                        r_in_cnt <= r_in_cnt + c_CNT_W'(1);
                        if (r_in_cnt == c_CNT_PRO_LAST) begin
                            r_state <= c_ST_COMPUTE;
                        end
                    end
                end
                c_ST_COMPUTE: begin
                    r_mag   <= w_border ? 8'd0 : w_mag;
                    r_state <= c_ST_OUTPUT;
                end
                c_ST_OUTPUT: begin
                    if (out_wr_en) begin
                        if (w_last) begin
                            r_state  <= c_ST_PROLOGUE;
                            r_in_cnt <= '0;
                            r_row    <= '0;
                            r_col    <= '0;
                        end else begin
                            r_state <= c_ST_COMPUTE;
                            if (in_rd_en) begin
                                r_in_cnt <= r_in_cnt + c_CNT_W'(1);
                            end
                            if (r_col == c_COL_LAST) begin
                                r_col <= '0;
                                r_row <= r_row + c_ROW_W'(1);
                            end else begin
                                r_col <= r_col + c_COL_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_PROLOGUE;
                end
            endcase
        end
    end

    assign out_din = r_mag;

`ifdef SOBEL_DIRECTION_EN
    logic [1:0] w_dir;
    logic [1:0] r_dir;

    sobel_dir_quant u_dir_quant (
        .gx  (w_gx),
        .gy  (w_gy),
        .dir (w_dir)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dir <= 2'(DIR_0);
        end else if (r_state == c_ST_COMPUTE) begin
            r_dir <= w_border ? 2'(DIR_0) : w_dir;
        end
    end

    assign out_dir = r_dir;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_gradient.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_gradient
// Brief    : Self-checking bench for sobel_gradient on an 8x6 image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_gradient;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NPIX = W * H;
    localparam int KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       in_empty = 1'b1;
    logic [7:0] in_dout  = 8'd0;
    logic       out_full = 1'b0;
    logic       in_rd_en;
    logic       out_wr_en;
    logic [7:0] out_din;
`ifdef SOBEL_DIRECTION_EN
    logic [1:0] out_dir;
    logic [1:0] exp_dir_q [$];
    logic [1:0] cap_dir   [0:127];
`endif

    sobel_gradient #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
`ifdef SOBEL_DIRECTION_EN
        .out_dir   (out_dir),
`endif
        .out_din   (out_din)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         wr_idx   = 0;
    int         pop_cnt  = 0;
    int         stall_writes = 0;
    int         stall_reads  = 0;
    bit         gap_en   = 1'b0;
    logic [7:0] in_q      [$];
    logic [7:0] exp_mag_q [$];
    logic [7:0] cap_mag   [0:127];
    logic [7:0] img       [H][W];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: direct 3x3 convolution over the stored image; returns {dir, mag}
    function automatic logic [9:0] model_px(input int r, input int c);
        int gx, gy, ax, ay, mag, dir;
        gx = 0;
        gy = 0;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 10'd0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                gx += KX[dr][dc] * int'(img[r+dr-1][c+dc-1]);
                gy += KY[dr][dc] * int'(img[r+dr-1][c+dc-1]);
            end
        end
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = (ax + ay > 255) ? 255 : ax + ay;
        if (5 * ay <= 2 * ax)      dir = 0;
        else if (2 * ay >= 5 * ax) dir = 2;
        else if ((gx < 0) == (gy < 0)) dir = 1;
        else dir = 3;
        return {dir[1:0], mag[7:0]};
    endfunction

    // kind: 0 uniform 100, 1 vertical step, 2 horizontal step, 3 diagonal ramp
    task automatic load(input int kind);
        logic [9:0] e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0:       img[r][c] = 8'd100;
                    1:       img[r][c] = (c >= 4) ? 8'd100 : 8'd0;
                    2:       img[r][c] = (r >= 3) ? 8'd50 : 8'd0;
                    default: img[r][c] = 8'(20 * (r + c));
                endcase
            end
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                in_q.push_back(img[r][c]);
                e = model_px(r, c);
                exp_mag_q.push_back(e[7:0]);
`ifdef SOBEL_DIRECTION_EN
                exp_dir_q.push_back(e[9:8]);
`endif
            end
        end
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int cyc;
        cyc = 0;
        while (wr_idx < n && cyc < budget) begin
            @(posedge clock);
            cyc++;
        end
        if (wr_idx < n) check({name, "_timeout"}, wr_idx, n);
        #2;
    endtask

    // Input FIFO model: first-word-fall-through, optional random empty gaps
    initial begin
        bit do_pop;
        forever begin
            @(negedge clock);
            do_pop = in_rd_en;
            if (in_rd_en && in_empty) check("rd_while_empty", 1, 0);
            if (do_pop) pop_cnt++;
            @(posedge clock);
            #1;
            if (do_pop && in_q.size() > 0) void'(in_q.pop_front());
            in_empty = (in_q.size() == 0) || (gap_en && $urandom_range(0, 2) == 0);
            in_dout  = (in_q.size() > 0) ? in_q[0] : 8'd0;
        end
    end

    // Output scoreboard: every write is compared against the model in order
    initial begin
        logic [7:0] m;
        forever begin
            @(negedge clock);
            if (out_full && in_rd_en) stall_reads++;
            if (reset && out_wr_en) begin
                if (out_full) stall_writes++;
                if (exp_mag_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    m = exp_mag_q.pop_front();
                    check($sformatf("mag[%0d]", wr_idx), int'(out_din), int'(m));
`ifdef SOBEL_DIRECTION_EN
                    check($sformatf("dir[%0d]", wr_idx), int'(out_dir), int'(exp_dir_q.pop_front()));
                    if (wr_idx < 128) cap_dir[wr_idx] = out_dir;
`endif
                    if (wr_idx < 128) cap_mag[wr_idx] = out_din;
                end
                wr_idx++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, writes %0d", wr_idx);
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         pops_before;
        logic [7:0] held;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_rd_en",  int'(in_rd_en),  0);
        check("rst_wr_en",  int'(out_wr_en), 0);
        check("rst_out_din", int'(out_din),  0);
`ifdef SOBEL_DIRECTION_EN
        check("rst_out_dir", int'(out_dir),  0);
`endif
        @(posedge clock);
        #2;
        reset = 1'b1;

        // Uniform frame followed back-to-back by a vertical step frame
        wr_idx  = 0;
        pop_cnt = 0;
        load(0);
        load(1);
        cyc = 0;
        while (pop_cnt < W + 2 && cyc < 200) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        check("prologue_pops", pop_cnt, W + 2);
        @(negedge clock); #1; check("lat_compute",     int'(out_wr_en), 0);
        @(negedge clock); #1; check("lat_first_write", int'(out_wr_en), 1);
        @(negedge clock); #1; check("thru_idle",       int'(out_wr_en), 0);
        @(negedge clock); #1; check("thru_second",     int'(out_wr_en), 1);
        wait_writes(2 * NPIX, 1000, "b2b");
        check("b2b_pops", pop_cnt, 2 * NPIX);
        check("b2b_left", exp_mag_q.size(), 0);
        check("uni_0_0",  int'(cap_mag[0]),  0);
        check("uni_1_1",  int'(cap_mag[9]),  0);
        check("uni_3_3",  int'(cap_mag[27]), 0);
        check("vst_2_3",  int'(cap_mag[NPIX + 19]), 255);
        check("vst_2_4",  int'(cap_mag[NPIX + 20]), 255);
        check("vst_4_4",  int'(cap_mag[NPIX + 36]), 255);
        check("vst_2_2",  int'(cap_mag[NPIX + 18]), 0);
        check("vst_0_3",  int'(cap_mag[NPIX + 3]),  0);
`ifdef SOBEL_DIRECTION_EN
        check("vst_dir_2_3", int'(cap_dir[NPIX + 19]), 0);
`endif

        // Horizontal step
        wr_idx  = 0;
        pop_cnt = 0;
        load(2);
        wait_writes(NPIX, 600, "hstep");
        check("hst_2_1", int'(cap_mag[17]), 200);
        check("hst_3_6", int'(cap_mag[30]), 200);
        check("hst_1_1", int'(cap_mag[9]),  0);
        check("hst_4_4", int'(cap_mag[36]), 0);
        check("hst_0_2", int'(cap_mag[2]),  0);
`ifdef SOBEL_DIRECTION_EN
        check("hst_dir_2_1", int'(cap_dir[17]), 2);
`endif

        // Diagonal ramp
        wr_idx  = 0;
        pop_cnt = 0;
        load(3);
        wait_writes(NPIX, 600, "ramp");
        check("rmp_1_1", int'(cap_mag[9]),  255);
        check("rmp_4_6", int'(cap_mag[38]), 255);
        check("rmp_5_5", int'(cap_mag[45]), 0);
        check("rmp_1_7", int'(cap_mag[15]), 0);
`ifdef SOBEL_DIRECTION_EN
        check("rmp_dir_1_1", int'(cap_dir[9]),  1);
        check("rmp_dir_4_6", int'(cap_dir[38]), 1);
`endif

        // Ramp again with input gaps and a 20-cycle output stall
        gap_en  = 1'b1;
        wr_idx  = 0;
        pop_cnt = 0;
        load(3);
        wait_writes(20, 600, "stall_pre");
        out_full = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        held         = out_din;
        stall_writes = 0;
        stall_reads  = 0;
        pops_before  = pop_cnt;
        repeat (18) @(negedge clock);
        #1;
        check("stall_writes",  stall_writes, 0);
        check("stall_reads",   stall_reads,  0);
        check("stall_pops",    pop_cnt, pops_before);
        check("stall_hold",    int'(out_din), int'(held));
        check("stall_wr_idx",  wr_idx, 20);
        @(posedge clock);
        #2;
        out_full = 1'b0;
        wait_writes(NPIX, 2000, "stall_post");
        gap_en = 1'b0;
        check("stall_frame_pops", pop_cnt, NPIX);
        check("stall_rmp_1_1", int'(cap_mag[9]), 255);

        // Reset in the middle of a frame, then a fresh uniform frame
        wr_idx = 0;
        load(3);
        wait_writes(20, 600, "mid_pre");
        reset    = 1'b0;
        in_q.delete();
        exp_mag_q.delete();
`ifdef SOBEL_DIRECTION_EN
        exp_dir_q.delete();
`endif
        in_empty = 1'b1;
        repeat (2) @(negedge clock);
        check("mid_rst_rd_en",   int'(in_rd_en),  0);
        check("mid_rst_wr_en",   int'(out_wr_en), 0);
        check("mid_rst_out_din", int'(out_din),   0);
        @(posedge clock);
        #2;
        reset   = 1'b1;
        wr_idx  = 0;
        pop_cnt = 0;
        load(0);
        wait_writes(NPIX, 600, "post_rst");
        repeat (40) @(posedge clock);
        check("post_rst_writes", wr_idx, NPIX);
        check("post_rst_pops",   pop_cnt, NPIX);
        check("post_rst_left",   exp_mag_q.size(), 0);
        check("post_rst_2_4",    int'(cap_mag[20]), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
